instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_if.sv | 25 ++
 rtl/instruction_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for instruction_loader.
interface instruction_loader_if;
  logic        start;
  logic        abort;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        checksum_err;

  modport master (
    output start, abort, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, checksum_err
  );

  modport slave (
    input  start, abort, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, checksum_err
  );
endinterface

// File: rtl/instruction_loader.sv
// Loads little-endian byte stream into instruction memory while holding the CPU.
// Define LOADER_CHECKSUM_EN to add a trailing 32-bit checksum (CHECK state).
//
// state | meaning
// IDLE  | waiting for start, CPU running
// RECV  | assembling a 4-byte word
// WRITE | one-cycle memory write of the assembled word
// CHECK | receiving expected checksum (LOADER_CHECKSUM_EN only)
// DONE  | one-cycle completion pulse
module instruction_loader #(
  parameter int DEPTH = 128
) (
  input logic clk,
  input logic rst,
  instruction_loader_if.slave bus
);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd3;
`endif

  logic [2:0]       state;
  logic [LEN_W-1:0] length;
  logic [IDX_W-1:0] word_index;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             accept;
  logic             last_word;
  logic [31:0]      assembled;

  assign accept    = bus.in_valid && bus.in_ready;
  // Newest byte lands on top; after four bytes the first one sits in [7:0].
  assign assembled = {bus.in_data, shift};
  assign last_word = (LEN_W'(word_index) + LEN_W'(1)) >= length;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_acc;
  logic        err_q;
  assign bus.in_ready     = (state == RECV) || (state == CHECK);
  assign bus.checksum_err = err_q;
`else
  assign bus.in_ready     = (state == RECV);
  assign bus.checksum_err = 1'b0;
`endif

  // Abort in the WRITE cycle suppresses the strobe as well as the state change.
  assign bus.mem_we    = (state == WRITE) && !bus.abort;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = (state != IDLE);
  assign bus.done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      length     <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_acc    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state      <= RECV;
            word_index <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            if (bus.word_count == 8'd0 || int'(bus.word_count) > DEPTH)
              length <= LEN_W'(DEPTH);
            else
              length <= LEN_W'(bus.word_count);
`ifdef LOADER_CHECKSUM_EN
            sum_acc <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (accept) begin
            shift    <= assembled[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr_q  <= 32'({word_index, 2'b00});
              wdata_q <= assembled;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            sum_acc <= sum_acc + wdata_q;
`endif
            if (!last_word) begin
              word_index <= word_index + IDX_W'(1);
              state      <= RECV;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (accept) begin
            shift    <= assembled[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (assembled != sum_acc) err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
